prbs8_checker: RTL and testbench
================================

# prbs8_checker

Byte-wide PRBS checker that consumes the 8-bit LFSR generator's `dout` stream and verifies it against the same tap polynomial. It self-seeds from the received stream and acquires lock after a run of correct bytes. While locked it flywheels its own predicted sequence, reporting per-byte mismatches and a saturating error count. It sits directly downstream of the generator, or at the far end of a link loop-back, in PRBS test paths.

## Interface
- `LOCK_CNT`, default 4: consecutive matching beats in HUNT required to enter LOCKED (≥1).
- `UNLOCK_CNT`, default 3: consecutive mismatching beats in LOCKED that force return to HUNT (≥1).
- `CNT_W`, default 16: width of `err_count`.
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `din_valid`  in  1: `din` carries a beat this cycle.
- `din`  in  8: received byte (generator `dout`).
- `tap`  in  8: feedback tap mask, same encoding as generator; sampled on every valid beat.
- `clear`  in  1: synchronous clear of `err_count`.
- `locked`  out  1: registered, high in LOCKED state.
- `err`  out  1: registered one-cycle pulse per mismatching beat while LOCKED.
- `err_count`  out  CNT_W: saturating count of mismatches while LOCKED.

## Operation
- Prediction on a valid beat: `exp = {prev[6:0], ^(prev & tap)}`; `match = (din == exp)`.
- States: IDLE, HUNT, LOCKED. Internal counters: `run` (match run) and `miss` (mismatch run).
- IDLE: the first valid beat sets `prev <= din`, `run <= 0`, and moves to HUNT.
- HUNT, every valid beat: `prev <= din` (re-seed).
  - A match with `din != 8'h00` increments `run`.
  - Otherwise `run <= 0`.
  - A match reaching `run == LOCK_CNT` moves to LOCKED with `miss <= 0`.
  - All-zero guard: `din == 8'h00` never counts as a match in HUNT.
  - Mismatches in HUNT do not assert `err` or count.
- LOCKED, every valid beat: `prev <= exp` (flywheel). A single corrupted byte therefore yields exactly one error.
  - Match: `miss <= 0`.
  - Mismatch: `err` pulse, `err_count` increments (saturating at all-ones), `miss` increments.
  - A mismatch reaching `miss == UNLOCK_CNT` moves to HUNT with `run <= 0`.
- `din_valid` low: no state or register change; `err` low.
- `tap` change while LOCKED is not detected specially. Resulting mismatches unlock through the normal `miss` path.
- `clear`: `err_count <= 0`. Clear wins over a simultaneous increment (result 0).

## Timing
- Reset: state IDLE, `prev = 0`, `run = miss = 0`, `locked = 0`, `err = 0`, `err_count = 0`.
- Reset mid-operation drops `locked` at the next edge. No error is reported for the interrupted beat.
- `err`, `locked` and `err_count` all update on the edge that consumes the beat, so they are visible one cycle after the beat.
- Lock latency with back-to-back beats: `locked` rises on the edge consuming the (LOCK_CNT+1)-th beat, i.e. 1 seed beat plus LOCK_CNT matches.
- Unlock: `locked` falls on the edge consuming the UNLOCK_CNT-th consecutive mismatch. That beat still pulses `err` and counts.
- Gaps in `din_valid` do not break runs; only valid beats advance counters.
- Throughput: one beat per cycle, no backpressure.

## Configuration
- `PRBS8_CHECKER_ERRCNT_EN` defined: the `err_count` register, its saturation logic and `clear` are compiled in, as described above.
- Not defined: `err_count` is tied to 0, `clear` is ignored, and no counter flops are instantiated. `err`, `locked` and the state machine are unchanged.

## Test plan
- Reset: hold `resetn = 0` for 3 cycles with random `din`/`din_valid` → `locked = 0`, `err = 0`, `err_count = 0` throughout.
- Lock: `tap = 8'hB8`, back-to-back beats `01, 02, 04, 08, 11` → `locked = 1` the cycle after the `11` beat; `err` never asserts.
- Single error: after lock, send `22` instead of `23`, then `47` → one `err` pulse, `err_count = 1`, `locked` stays 1, no `err` on the `47` beat (flywheel).
- Unlock and relock: after lock, send three wrong bytes `FF, FF, FF` → three `err` pulses, `err_count = 3`, `locked = 0` after the third. Then a fresh 5-beat correct run relocks.
- Zero stream: `tap = 8'hB8`, ten beats of `00` from reset → `locked` stays 0, `err` never asserts.
- Counter edges with `CNT_W = 2`: five errors while locked (interleaved with matches) → `err_count` saturates at 3. `clear` on the same cycle as an error beat → `err_count = 0`. With the macro undefined, `err_count` stays 0.

Source files
------------

// File: rtl/prbs8_checker.sv
// Byte-wide PRBS checker: self-seeds from the received stream, locks after LOCK_CNT matches, then flywheels.
// Optional error counter compiled in with `define PRBS8_CHECKER_ERRCNT_EN.
module prbs8_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic [7:0]       tap,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_prev, w_prev_nxt;
  logic [RUN_W-1:0]    r_run, w_run_nxt;
  logic [MISS_W-1:0]   r_miss, w_miss_nxt;
  logic                r_locked, r_err, w_err_nxt;

  logic [7:0]          w_exp;
  logic                w_match;
  logic [RUN_W-1:0]    w_run_inc;
  logic [MISS_W-1:0]   w_miss_inc;

  assign w_exp      = {r_prev[6:0], ^(r_prev & tap)};
  assign w_match    = (din == w_exp);
  assign w_run_inc  = r_run + RUN_W'(1);
  assign w_miss_inc = r_miss + MISS_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_prev   <= '0;
      r_run    <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_run    <= w_run_nxt;
      r_miss   <= w_miss_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    w_err_nxt   = 1'b0;
    if (din_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_prev_nxt  = din;
          w_run_nxt   = '0;
          w_state_nxt = ST_HUNT;
        end
        ST_HUNT: begin
          w_prev_nxt = din;
          // An all-zero byte is a fixed point of the LFSR, so it never counts towards lock
          if (w_match && (din != 8'h00)) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == RUN_W'(LOCK_CNT)) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on the prediction so one corrupted byte costs exactly one error
          w_prev_nxt = w_exp;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt  = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == MISS_W'(UNLOCK_CNT)) begin
              w_state_nxt = ST_HUNT;
              w_run_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign locked = r_locked;
  assign err    = r_err;

`ifdef PRBS8_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_count <= '0;
    end else if (clear) begin
      r_err_count <= '0;
    end else if (w_err_nxt && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear;
  assign err_count      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: a default instance and a CNT_W=2 instance share stimulus.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        resetn, din_valid, clear;
  logic [7:0]  din, tap;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned exp_a     = 0;
  int unsigned exp_b     = 0;

  always #5 clk = ~clk;

  prbs8_checker dut_a (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .tap(tap),
    .clear(clear), .locked(locked_a), .err(err_a), .err_count(cnt_a)
  );

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .tap(tap),
    .clear(clear), .locked(locked_b), .err(err_b), .err_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic e_err, input logic e_lock);
    chk({tag, "_err_a"},    32'(err_a),    32'(e_err));
    chk({tag, "_lock_a"},   32'(locked_a), 32'(e_lock));
    chk({tag, "_cnt_a"},    32'(cnt_a),    exp_a);
    chk({tag, "_err_b"},    32'(err_b),    32'(e_err));
    chk({tag, "_lock_b"},   32'(locked_b), 32'(e_lock));
    chk({tag, "_cnt_b"},    32'(cnt_b),    exp_b);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr,
                      input logic e_err, input logic e_lock, input string tag);
    din_valid = v;
    din       = d;
    clear     = clr;
    @(posedge clk);
    #1;
`ifdef PRBS8_CHECKER_ERRCNT_EN
    if (clr) begin
      exp_a = 0;
      exp_b = 0;
    end else if (e_err) begin
      if (exp_a < 65535) exp_a++;
      if (exp_b < 3)     exp_b++;
    end
`else
    exp_a = 0;
    exp_b = 0;
`endif
    check_all(tag, e_err, e_lock);
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic rst_cycle(input string tag);
    resetn    = 1'b0;
    din_valid = 1'($urandom);
    din       = 8'($urandom);
    @(posedge clk);
    #1;
    exp_a = 0;
    exp_b = 0;
    check_all(tag, 1'b0, 1'b0);
    resetn    = 1'b1;
    din_valid = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    tap       = 8'hB8;
    clear     = 1'b0;

    // Reset held three cycles with random traffic
    for (int i = 0; i < 3; i++) begin
      rst_cycle("reset");
      resetn = 1'b0;
    end
    resetn = 1'b1;

    // All-zero stream never locks
    for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "zero");

    rst_cycle("reset2");

    // Lock: seed 01 then four matches, with a valid gap inside the run
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "lock_01");
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "lock_02");
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, "lock_04");
    step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, "lock_gap");
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, "lock_08");
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, "lock_11");

    // Single corrupted byte: 22 instead of 23, flywheel makes 47 correct
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, "single_22");
    step(1'b1, 8'h47, 1'b0, 1'b0, 1'b1, "single_47");

    // Clear on a matching beat, then three mismatches unlock
    step(1'b1, 8'h8E, 1'b1, 1'b0, 1'b1, "clear_8E");
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, "match_1C");
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, "unlock_ff1");
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, "unlock_ff2");
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, "unlock_ff3");

    // Relock after a fresh 5-beat correct run; HUNT mismatches are silent
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "relock_01");
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "relock_02");
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, "relock_04");
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, "relock_08");
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, "relock_11");

    // Five errors interleaved with matches: CNT_W=2 instance saturates at 3
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, "sat_e1");
    step(1'b1, 8'h47, 1'b0, 1'b0, 1'b1, "sat_m1");
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, "sat_e2");
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, "sat_m2");
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, "sat_e3");
    step(1'b1, 8'h71, 1'b0, 1'b0, 1'b1, "sat_m3");
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, "sat_e4");
    step(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, "sat_m4");
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, "sat_e5");
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, "sat_m5");

    // Clear coincident with an error beat wins
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, "clear_on_err");
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, "err_after_clr");
    step(1'b1, 8'h97, 1'b0, 1'b0, 1'b1, "match_97");

    // Invalid beats change nothing; clear still acts
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "idle_beat");
    step(1'b0, 8'h33, 1'b1, 1'b0, 1'b1, "idle_clear");

    // Reset while locked with a mismatching beat present
    resetn = 1'b0;
    rst_cycle("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
